// File: rtl/alu_mdu_if.sv
// Operand/result handshake bundle between the multicycle control path and alu_mdu.
interface alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_hi;
    logic             co;
    logic             overflow;
    logic             zero;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res, res_hi, co, overflow, zero, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res, res_hi, co, overflow, zero, busy
    );
endinterface

// File: rtl/alu_mdu.sv
// Registered ALU with iterative unsigned MUL/DIV/REM behind a valid/ready handshake.
// Define ALU_MDU_EN to build the iterative multiply/divide datapath; otherwise ops 8-10 are illegal.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_mdu_if.slave bus
);
`ifdef ALU_MDU_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] res_q, res_hi_q;
    logic             co_q, ov_q;
    logic             accept;

    // single-cycle ALU, evaluated directly on the presented operands
    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_co, alu_ov;

    assign accept = bus.in_valid && (state == IDLE);

    always_comb begin
        sub     = (bus.op == 4'd6);
        bx      = bus.b ^ {WIDTH{sub}};
        sum     = {1'b0, bus.a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
        alu_res = '0;
        alu_co  = 1'b0;
        alu_ov  = 1'b0;
        case (bus.op)
            4'd0: alu_res = bus.a & bus.b;
            4'd1: alu_res = bus.a | bus.b;
            4'd3: alu_res = bus.a ^ bus.b;
            4'd4: alu_res = ~(bus.a | bus.b);
            4'd5: alu_res = bus.b >> 1;
            4'd7: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            4'd2, 4'd6: begin
                alu_res = sum[WIDTH-1:0];
                alu_co  = sum[WIDTH];
                alu_ov  = (bus.a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MDU_EN
    // hi_q/lo_q hold product-high/multiplier for MULU and remainder/quotient for DIVU/REMU
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] hi_q, lo_q, opd_q;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             is_iter, last;

    assign is_iter = (bus.op == 4'd8) || (bus.op == 4'd9) || (bus.op == 4'd10);
    assign last    = (cnt == CNT_W'(WIDTH-1));

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opd_q};
        hi_nxt  = hi_q;
        lo_nxt  = lo_q;
        if (op_q == 4'd8) begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (!diff[WIDTH+1]) begin
            hi_nxt = diff[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_nxt = shifted[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid) begin
`ifdef ALU_MDU_EN
                state_nxt = is_iter ? BUSY : DONE;
`else
                state_nxt = DONE;
`endif
            end
`ifdef ALU_MDU_EN
            BUSY: if (last) state_nxt = DONE;
`endif
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            res_q    <= '0;
            res_hi_q <= '0;
            co_q     <= 1'b0;
            ov_q     <= 1'b0;
`ifdef ALU_MDU_EN
            cnt      <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
`endif
        end else begin
            state <= state_nxt;
            // iterative ops decode to 0 here and get overwritten on the last iteration
            if (accept) begin
                res_q    <= alu_res;
                res_hi_q <= '0;
                co_q     <= alu_co;
                ov_q     <= alu_ov;
            end
`ifdef ALU_MDU_EN
            if (accept) begin
                op_q  <= bus.op;
                hi_q  <= '0;
                lo_q  <= bus.a;
                opd_q <= bus.b;
                cnt   <= '0;
            end
            if (state == BUSY) begin
                hi_q <= hi_nxt;
                lo_q <= lo_nxt;
                cnt  <= cnt + CNT_W'(1);
                if (last) begin
                    res_q    <= (op_q == 4'd10) ? hi_nxt : lo_nxt;
                    res_hi_q <= hi_nxt;
                end
            end
`endif
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
`ifdef ALU_MDU_EN
    assign bus.busy      = (state == BUSY);
`else
    assign bus.busy      = 1'b0;
`endif
    assign bus.res       = res_q;
    assign bus.res_hi    = res_hi_q;
    assign bus.co        = co_q;
    assign bus.overflow  = ov_q;
    assign bus.zero      = (res_q == '0);
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: table of single/iterative ops plus backpressure and reset sequences.
module tb_alu_mdu;
    localparam int W = 32;
`ifdef ALU_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mdu_if #(.WIDTH(W)) bus ();
    alu_mdu #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] res, hi;
        logic         co, ov, z;
        int           lat, bsy;
    } vec_t;

    typedef struct {
        logic [W-1:0] res, hi;
        logic         co, ov, z;
        int           lat, bsy;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Iterative ops without the MDU build fall back to the illegal-op result.
    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] res, input logic [W-1:0] hi,
                                input logic co, input logic ov);
        vec_t v;
        bit   iter;
        iter  = (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
        v.op  = op; v.a = a; v.b = b;
        v.res = (iter && !MDU) ? '0 : res;
        v.hi  = (iter && !MDU) ? '0 : hi;
        v.co  = co; v.ov = ov;
        v.z   = (v.res == '0);
        v.lat = (iter && MDU) ? W + 1 : 1;
        v.bsy = (iter && MDU) ? W : 0;
        return v;
    endfunction

    task automatic issue(input string nm, input vec_t v, input bit rdy);
        exp_t e;
        int   lat, bc;
        bit   seen;
        sbq.push_back('{v.res, v.hi, v.co, v.ov, v.z, v.lat, v.bsy});
        @(negedge clk);
        chk({nm, " in_ready"}, bus.in_ready, 1);
        bus.op = v.op; bus.a = v.a; bus.b = v.b;
        bus.in_valid = 1'b1; bus.out_ready = rdy;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0; bc = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.busy) bc++;
            if (bus.out_valid) seen = 1'b1;
        end
        e = sbq.pop_front();
        chk({nm, " out_valid"}, seen, 1);
        chk({nm, " latency"}, lat, e.lat);
        chk({nm, " busy_cycles"}, bc, e.bsy);
        chk({nm, " res"}, bus.res, e.res);
        chk({nm, " res_hi"}, bus.res_hi, e.hi);
        chk({nm, " co"}, bus.co, e.co);
        chk({nm, " overflow"}, bus.overflow, e.ov);
        chk({nm, " zero"}, bus.zero, e.z);
        if (rdy) @(posedge clk);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " in_ready"}, bus.in_ready, 1);
        chk({nm, " out_valid"}, bus.out_valid, 0);
        chk({nm, " busy"}, bus.busy, 0);
        chk({nm, " res"}, bus.res, 0);
        chk({nm, " res_hi"}, bus.res_hi, 0);
        chk({nm, " co"}, bus.co, 0);
        chk({nm, " overflow"}, bus.overflow, 0);
        chk({nm, " zero"}, bus.zero, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.op = '0; bus.a = '0; bus.b = '0;

        tbl.push_back(mk(4'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 1, 0));
        tbl.push_back(mk(4'd6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1));
        tbl.push_back(mk(4'd7, 32'h00000001, 32'h00000002, 32'h00000001, 0, 0, 0));
        tbl.push_back(mk(4'd7, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 0, 0, 0));
        tbl.push_back(mk(4'd0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0));
        tbl.push_back(mk(4'd1, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 0, 0, 0));
        tbl.push_back(mk(4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 0, 0, 0));
        tbl.push_back(mk(4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 0, 0, 0));
        tbl.push_back(mk(4'd5, 32'h12345678, 32'h80000001, 32'h40000000, 0, 0, 0));
        tbl.push_back(mk(4'd2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1));
        tbl.push_back(mk(4'd6, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 0, 0, 0));
        tbl.push_back(mk(4'd6, 32'h00000007, 32'h00000007, 32'h00000000, 0, 1, 0));
        tbl.push_back(mk(4'd12, 32'h00000005, 32'h00000003, 32'h00000000, 0, 0, 0));
        tbl.push_back(mk(4'd8, 32'h00010000, 32'h00030000, 32'h00000000, 32'h00000003, 0, 0));
        tbl.push_back(mk(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 0, 0));
        tbl.push_back(mk(4'd9, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0));
        tbl.push_back(mk(4'd10, 32'd100, 32'd7, 32'd2, 32'd2, 0, 0));
        tbl.push_back(mk(4'd9, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 0, 0));
        tbl.push_back(mk(4'd9, 32'hFFFFFFFF, 32'd10, 32'h19999999, 32'd5, 0, 0));

        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            issue($sformatf("vec%0d", i), tbl[i], 1'b1);

        // backpressure: result held, second op ignored while in DONE
        issue("bp", mk(4'd6, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 0), 1'b0);
        bus.op = 4'd2; bus.a = 32'd1; bus.b = 32'd1; bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d out_valid", i), bus.out_valid, 1);
            chk($sformatf("bp hold%0d in_ready", i), bus.in_ready, 0);
            chk($sformatf("bp hold%0d res", i), bus.res, 32'hFFFFFFFE);
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp release out_valid", bus.out_valid, 0);
        chk("bp release in_ready", bus.in_ready, 1);
        @(negedge clk);
        chk("bp no stray out_valid", bus.out_valid, 0);
        chk("bp res kept", bus.res, 32'hFFFFFFFE);

`ifdef ALU_MDU_EN
        // reset during MULU iteration 10
        @(negedge clk);
        bus.op = 4'd8; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid busy", bus.busy, 1);
`else
        // reset while a result waits in DONE
        issue("pre_rst", mk(4'd6, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 0), 1'b0);
`endif
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1; bus.out_ready = 1'b1;
        issue("post_rst add", mk(4'd2, 32'd2, 32'd3, 32'd5, 0, 0, 0), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
